// File: rtl/mem_lsu.sv
// Load/store unit: one held dbus transaction per request, lane-aligned data, registered writeback.
// Optional macro LSU_MISALIGN_TRAP_EN: trap misaligned accesses instead of aligning them down.
module mem_lsu #(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int TIMEOUT = 0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    input  logic            i_dbus_re,
    input  logic            i_dbus_we,
    input  logic [2:0]      i_func3,
    input  logic [AW-1:0]   i_addr,
    input  logic [DW-1:0]   i_rs2_data,
    input  logic [4:0]      i_rd_addr,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_err,
    output logic            o_rd_we,
    output logic [4:0]      o_rd_addr,
    output logic [DW-1:0]   o_rd_wdata,
    output logic            o_dbus_req,
    output logic            o_dbus_we,
    output logic [AW-1:0]   o_dbus_addr,
    output logic [DW/8-1:0] o_dbus_sel,
    output logic [DW-1:0]   o_dbus_wdata,
    input  logic [DW-1:0]   i_dbus_rdata,
    input  logic            i_dbus_rsp
);
    localparam int NB       = DW / 8;
    localparam int OFFW     = $clog2(NB);
    localparam int CW       = $clog2(TIMEOUT + 2);
    localparam int TMO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    typedef struct packed {
        logic            load;
        logic            uns;
        logic [1:0]      size;
        logic [OFFW-1:0] off;
        logic [4:0]      rd;
    } req_t;

    state_t          state, state_nxt;
    req_t            req_q;
    logic            err_q;
    logic [CW-1:0]   tmo_cnt;

    logic            accept, bad, tmo_hit;
    logic [7:0]      lane_m, align_m;
    logic [OFFW-1:0] off_al;
    logic [NB-1:0]   size_sel;
    logic [DW-1:0]   bmask, wdata_nxt, rsh, ld_ext;

    // Request decode from the live inputs; only meaningful while IDLE.
    always_comb begin
        case (i_func3[1:0])
            2'd0:    begin lane_m = 8'h01; align_m = 8'h00; end
            2'd1:    begin lane_m = 8'h03; align_m = 8'h01; end
            2'd2:    begin lane_m = 8'h0F; align_m = 8'h03; end
            default: begin lane_m = 8'hFF; align_m = 8'h07; end
        endcase
        off_al   = i_addr[OFFW-1:0] & ~align_m[OFFW-1:0];
        size_sel = NB'(lane_m);
        for (int b = 0; b < NB; b++) bmask[8*b +: 8] = {8{size_sel[b]}};
        wdata_nxt = (i_rs2_data & bmask) << {off_al, 3'b000};
        bad = ((i_func3[1:0] == 2'd3) && (DW == 32)) || (!i_dbus_re && i_func3[2]);
`ifdef LSU_MISALIGN_TRAP_EN
        bad = bad || (|(i_addr[OFFW-1:0] & align_m[OFFW-1:0]));
`endif
    end

    assign accept  = (state == IDLE) && i_valid && (i_dbus_re || i_dbus_we);
    assign tmo_hit = (TIMEOUT > 0) && (tmo_cnt == CW'(TMO_LAST));

    // Load extension: upper bits are filled with the access's sign bit unless unsigned.
    always_comb begin
        rsh = i_dbus_rdata >> {req_q.off, 3'b000};
        case (req_q.size)
            2'd0:    ld_ext = DW'(rsh[7:0])  | ({DW{~req_q.uns & rsh[7]}}  << 8);
            2'd1:    ld_ext = DW'(rsh[15:0]) | ({DW{~req_q.uns & rsh[15]}} << 16);
            2'd2:    ld_ext = DW'(rsh[31:0]) | ({DW{~req_q.uns & rsh[31]}} << 32);
            default: ld_ext = rsh;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = bad ? DONE : REQ;
            REQ:     if (i_dbus_rsp || tmo_hit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            req_q        <= '0;
            err_q        <= 1'b0;
            tmo_cnt      <= '0;
            o_rd_addr    <= '0;
            o_rd_wdata   <= '0;
            o_dbus_req   <= 1'b0;
            o_dbus_we    <= 1'b0;
            o_dbus_addr  <= '0;
            o_dbus_sel   <= '0;
            o_dbus_wdata <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    req_q   <= '{load: i_dbus_re, uns: i_func3[2], size: i_func3[1:0],
                                 off: off_al, rd: i_rd_addr};
                    err_q   <= bad;
                    tmo_cnt <= '0;
                    if (!bad) begin
                        o_dbus_req   <= 1'b1;
                        o_dbus_we    <= ~i_dbus_re;
                        o_dbus_addr  <= {i_addr[AW-1:OFFW], OFFW'(0)};
                        o_dbus_sel   <= size_sel << off_al;
                        o_dbus_wdata <= i_dbus_re ? '0 : wdata_nxt;
                    end
                end
                REQ: begin
                    if (i_dbus_rsp || tmo_hit) begin
                        o_dbus_req   <= 1'b0;
                        o_dbus_we    <= 1'b0;
                        o_dbus_addr  <= '0;
                        o_dbus_sel   <= '0;
                        o_dbus_wdata <= '0;
                    end
                    if (i_dbus_rsp) begin
                        if (req_q.load) begin
                            o_rd_wdata <= ld_ext;
                            o_rd_addr  <= req_q.rd;
                        end
                    end else if (tmo_hit) begin
                        err_q <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy  = (state != IDLE);
    assign o_done  = (state == DONE);
    assign o_err   = o_done & err_q;
    assign o_rd_we = o_done & req_q.load & ~err_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: a DW=32/TIMEOUT=4 instance and a DW=64 instance.
module tb_mem_lsu;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // DW=32 instance signals
    logic        a_valid, a_re, a_we, a_rsp;
    logic [2:0]  a_f3;
    logic [31:0] a_addr, a_rs2, a_rdata;
    logic [4:0]  a_rd;
    logic        a_busy, a_done, a_err, a_rd_we, a_req, a_bwe;
    logic [4:0]  a_rd_addr;
    logic [31:0] a_rd_wdata, a_baddr, a_bwdata;
    logic [3:0]  a_sel;

    // DW=64 instance signals
    logic        b_valid, b_re, b_we, b_rsp;
    logic [2:0]  b_f3;
    logic [31:0] b_addr;
    logic [63:0] b_rs2, b_rdata;
    logic [4:0]  b_rd;
    logic        b_busy, b_done, b_err, b_rd_we, b_req, b_bwe;
    logic [4:0]  b_rd_addr;
    logic [63:0] b_rd_wdata, b_bwdata;
    logic [31:0] b_baddr;
    logic [7:0]  b_sel;

    mem_lsu #(.DW(32), .AW(32), .TIMEOUT(4)) u_dut32 (
        .i_clk(clk), .i_rst(rst), .i_valid(a_valid), .i_dbus_re(a_re), .i_dbus_we(a_we),
        .i_func3(a_f3), .i_addr(a_addr), .i_rs2_data(a_rs2), .i_rd_addr(a_rd),
        .o_busy(a_busy), .o_done(a_done), .o_err(a_err), .o_rd_we(a_rd_we),
        .o_rd_addr(a_rd_addr), .o_rd_wdata(a_rd_wdata), .o_dbus_req(a_req),
        .o_dbus_we(a_bwe), .o_dbus_addr(a_baddr), .o_dbus_sel(a_sel),
        .o_dbus_wdata(a_bwdata), .i_dbus_rdata(a_rdata), .i_dbus_rsp(a_rsp)
    );

    mem_lsu #(.DW(64), .AW(32), .TIMEOUT(0)) u_dut64 (
        .i_clk(clk), .i_rst(rst), .i_valid(b_valid), .i_dbus_re(b_re), .i_dbus_we(b_we),
        .i_func3(b_f3), .i_addr(b_addr), .i_rs2_data(b_rs2), .i_rd_addr(b_rd),
        .o_busy(b_busy), .o_done(b_done), .o_err(b_err), .o_rd_we(b_rd_we),
        .o_rd_addr(b_rd_addr), .o_rd_wdata(b_rd_wdata), .o_dbus_req(b_req),
        .o_dbus_we(b_bwe), .o_dbus_addr(b_baddr), .o_dbus_sel(b_sel),
        .o_dbus_wdata(b_bwdata), .i_dbus_rdata(b_rdata), .i_dbus_rsp(b_rsp)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] last_res;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present a request for one cycle; returns at the negedge of cycle 1.
    task automatic issue32(input logic re, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] rs2, input logic [4:0] rd);
        @(negedge clk);
        a_valid = 1'b1; a_re = re; a_we = we; a_f3 = f3; a_addr = addr; a_rs2 = rs2; a_rd = rd;
        @(negedge clk);
        a_valid = 1'b0; a_re = 1'b0; a_we = 1'b0;
    endtask

    task automatic load32(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] rdata, input logic [4:0] rd,
                          input logic [3:0] esel, input logic [31:0] eaddr, input logic [31:0] eres);
        issue32(1'b1, we, f3, addr, 32'h0, rd);
        chk({tag, ".req"}, a_req, 1);
        chk({tag, ".bwe"}, a_bwe, 0);
        chk({tag, ".sel"}, a_sel, esel);
        chk({tag, ".addr"}, a_baddr, eaddr);
        a_rdata = rdata; a_rsp = 1'b1;
        @(negedge clk);
        a_rsp = 1'b0; a_rdata = 32'hDEAD_DEAD;
        chk({tag, ".done"}, a_done, 1);
        chk({tag, ".err"}, a_err, 0);
        chk({tag, ".rd_we"}, a_rd_we, 1);
        chk({tag, ".res"}, a_rd_wdata, eres);
        chk({tag, ".rd"}, a_rd_addr, rd);
        chk({tag, ".req_off"}, a_req, 0);
        @(negedge clk);
        chk({tag, ".idle"}, {a_busy, a_done, a_rd_we}, 0);
    endtask

    task automatic err32(input string tag, input logic re, input logic we,
                         input logic [2:0] f3, input logic [31:0] addr);
        issue32(re, we, f3, addr, 32'h1234_5678, 5'd9);
        chk({tag, ".done"}, a_done, 1);
        chk({tag, ".err"}, a_err, 1);
        chk({tag, ".req"}, a_req, 0);
        chk({tag, ".rd_we"}, a_rd_we, 0);
        @(negedge clk);
        chk({tag, ".idle"}, {a_busy, a_done, a_err}, 0);
    endtask

    task automatic load64(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [63:0] rdata, input logic [7:0] esel, input logic [31:0] eaddr,
                          input logic [63:0] eres);
        @(negedge clk);
        b_valid = 1'b1; b_re = 1'b1; b_we = 1'b0; b_f3 = f3; b_addr = addr; b_rd = 5'd7;
        @(negedge clk);
        b_valid = 1'b0; b_re = 1'b0;
        chk({tag, ".req"}, b_req, 1);
        chk({tag, ".sel"}, b_sel, esel);
        chk({tag, ".addr"}, b_baddr, eaddr);
        b_rdata = rdata; b_rsp = 1'b1;
        @(negedge clk);
        b_rsp = 1'b0;
        chk({tag, ".done"}, b_done, 1);
        chk({tag, ".rd_we"}, b_rd_we, 1);
        chk({tag, ".res"}, b_rd_wdata, eres);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        a_valid = 0; a_re = 0; a_we = 0; a_rsp = 0; a_f3 = 0; a_addr = 0; a_rs2 = 0; a_rdata = 0; a_rd = 0;
        b_valid = 0; b_re = 0; b_we = 0; b_rsp = 0; b_f3 = 0; b_addr = 0; b_rs2 = 0; b_rdata = 0; b_rd = 0;
        repeat (2) @(negedge clk);
        chk("rst.a_ctl", {a_busy, a_done, a_err, a_rd_we, a_req, a_bwe}, 0);
        chk("rst.a_data", {a_sel, a_baddr, a_bwdata, a_rd_wdata, a_rd_addr}, 0);
        chk("rst.b_ctl", {b_busy, b_done, b_err, b_rd_we, b_req, b_bwe, b_sel}, 0);
        chk("rst.b_data", b_rd_wdata, 0);
        rst = 1'b0;

        load32("lw",  1'b0, 3'b010, 32'h1000, 32'h8765_4321, 5'd5, 4'hF, 32'h1000, 32'h8765_4321);
        load32("lwu", 1'b0, 3'b110, 32'h1000, 32'h8765_4321, 5'd6, 4'hF, 32'h1000, 32'h8765_4321);
        load32("lb",  1'b0, 3'b000, 32'h1003, 32'h8012_3456, 5'd1, 4'h8, 32'h1000, 32'hFFFF_FF80);
        load32("lbu", 1'b0, 3'b100, 32'h1003, 32'h8012_3456, 5'd2, 4'h8, 32'h1000, 32'h0000_0080);
        load32("lh",  1'b0, 3'b001, 32'h1002, 32'h9ABC_1234, 5'd3, 4'hC, 32'h1000, 32'hFFFF_9ABC);
        load32("lrw", 1'b1, 3'b010, 32'h1004, 32'h0000_1111, 5'd4, 4'hF, 32'h1004, 32'h0000_1111);
        last_res = 32'h0000_1111;

        // Store halfword with a 3-cycle response delay
        issue32(1'b0, 1'b1, 3'b001, 32'h2002, 32'h0000_BEEF, 5'd0);
        for (int i = 0; i < 3; i++) begin
            chk("sh.req", a_req, 1);
            chk("sh.bwe", a_bwe, 1);
            chk("sh.sel", a_sel, 4'hC);
            chk("sh.wdata", a_bwdata, 32'hBEEF_0000);
            chk("sh.addr", a_baddr, 32'h2000);
            chk("sh.nodone", a_done, 0);
            @(negedge clk);
        end
        a_rsp = 1'b1;
        @(negedge clk);
        a_rsp = 1'b0;
        chk("sh.done", a_done, 1);
        chk("sh.err", a_err, 0);
        chk("sh.rd_we", a_rd_we, 0);
        chk("sh.hold", a_rd_wdata, last_res);
        @(negedge clk);

`ifdef LSU_MISALIGN_TRAP_EN
        err32("mis", 1'b1, 1'b0, 3'b010, 32'h1001);
`else
        load32("mis", 1'b0, 3'b010, 32'h1001, 32'h1122_3344, 5'd8, 4'hF, 32'h1000, 32'h1122_3344);
        last_res = 32'h1122_3344;
`endif
        err32("ld32", 1'b1, 1'b0, 3'b011, 32'h1000);
        err32("sus",  1'b0, 1'b1, 3'b110, 32'h1000);
        chk("err.hold", a_rd_wdata, last_res);

        // Timeout: four request cycles, then an error completion; a late rsp is ignored
        issue32(1'b1, 1'b0, 3'b010, 32'h3000, 32'h0, 5'd10);
        for (int i = 0; i < 4; i++) begin
            chk("tmo.req", a_req, 1);
            chk("tmo.nodone", a_done, 0);
            @(negedge clk);
        end
        chk("tmo.done", a_done, 1);
        chk("tmo.err", a_err, 1);
        chk("tmo.req_off", a_req, 0);
        chk("tmo.rd_we", a_rd_we, 0);
        a_rsp = 1'b1; a_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        chk("late.idle", {a_busy, a_done}, 0);
        @(negedge clk);
        a_rsp = 1'b0;
        chk("late.nodone", a_done, 0);
        chk("late.hold", a_rd_wdata, last_res);

        // Reset in the middle of a request
        issue32(1'b1, 1'b0, 3'b010, 32'h4000, 32'h0, 5'd11);
        chk("mrst.req", a_req, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst.out", {a_req, a_done, a_busy, a_rd_we, a_sel}, 0);
        chk("mrst.res", a_rd_wdata, 0);
        @(negedge clk);
        chk("mrst.nodone", {a_done, a_busy}, 0);

        // DW=64 instance
        load64("ld64", 3'b011, 32'h8, 64'h0123_4567_89AB_CDEF, 8'hFF, 32'h8, 64'h0123_4567_89AB_CDEF);
        load64("lw64", 3'b010, 32'hC, 64'hFFFF_FFFE_0000_0000, 8'hF0, 32'h8, 64'hFFFF_FFFF_FFFF_FFFE);
        @(negedge clk);
        b_valid = 1'b1; b_we = 1'b1; b_f3 = 3'b000; b_addr = 32'h5; b_rs2 = 64'hAB;
        @(negedge clk);
        b_valid = 1'b0; b_we = 1'b0;
        chk("sb64.sel", b_sel, 8'h20);
        chk("sb64.wdata", b_bwdata, 64'h0000_AB00_0000_0000);
        chk("sb64.addr", b_baddr, 32'h0);
        b_rsp = 1'b1;
        @(negedge clk);
        b_rsp = 1'b0;
        chk("sb64.done", {b_done, b_rd_we}, 2'b10);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
